// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised CPU memory: default geometry,
// controller state encoding and bus decode constants.
package ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Controller states: CLEAR exists only when the clear sweep is built.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Meaning of the WR pin while CS is asserted (low).
  localparam logic WR_WRITE = 1'b0;
  localparam logic WR_READ  = 1'b1;

  // Index width needed to address DEPTH words (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Bare storage array: one synchronous write port and one registered read
// port. The read register is cleared by reset so DOUT starts at zero.
module ram_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_reg;

  // Write port: storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/param_ram.sv
// Parametrised single-port data/program memory for the 8-bit CPU.
// Registered read with DVALID strobe, out-of-range detection on ERR.
// Optional feature macro RAM_CLEAR_EN: after reset, a sweep writes
// CLEAR_VAL to every word while BUSY is high and bus accesses are ignored.
module param_ram
  import ram_pkg::*;
#(
  parameter int              DATA_W    = DEF_DATA_W,
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter int              DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              err,
  output logic              busy
);

  localparam int                IDX_W     = idx_width(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic             in_range;
  logic             access;
  logic             rd_req;
  logic             wr_req;
  logic             oor;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sweep_addr;
  logic             dvalid_reg;
  logic             err_reg;

`ifdef RAM_CLEAR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;

  // State and sweep counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sweep one word per cycle; leave CLEAR after the last word is written.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == CLEAR) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == LAST_IDX) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end
  end

  assign busy       = (state_reg == CLEAR);
  assign sweep_addr = cnt_reg;
`else
  assign busy       = 1'b0;
  assign sweep_addr = '0;
`endif

  // Full address is range-checked so high addresses never alias low words.
  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign idx      = addr[IDX_W-1:0];
  assign access   = !busy && !cs;
  assign rd_req   = access && (wr == WR_READ)  && in_range;
  assign wr_req   = access && (wr == WR_WRITE) && in_range;
  assign oor      = access && !in_range;

  // The sweep owns the write port while busy.
  ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (busy || wr_req),
    .waddr (busy ? sweep_addr : idx),
    .wdata (busy ? CLEAR_VAL : din),
    .re    (rd_req),
    .raddr (idx),
    .rdata (dout)
  );

  // One-cycle strobes aligned with the registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      dvalid_reg <= rd_req;
      err_reg    <= oor;
    end
  end

  assign dvalid = dvalid_reg;
  assign err    = err_reg;

endmodule
